// File: rtl/spatz_pkg.sv
// Shared Spatz types: VRF element address/data/byte-enable and the write request bundle.
package spatz_pkg;

  typedef logic [7:0]  vreg_addr_t;
  typedef logic [31:0] vreg_data_t;
  typedef logic [3:0]  vreg_be_t;

  typedef struct packed {
    vreg_addr_t addr;
    vreg_data_t data;
    vreg_be_t   be;
  } vrf_wreq_t;

  localparam int unsigned NrVrfWrReq = 3;

endpackage

// File: rtl/spatz_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr_i, wrapping modulo NR_REQ.
module spatz_rr_pick #(
  parameter int unsigned NR_REQ    = 3,
  parameter int unsigned IDX_WIDTH = $clog2(NR_REQ)
) (
  input  logic [NR_REQ-1:0]    valid_i,
  input  logic [IDX_WIDTH-1:0] ptr_i,
  output logic [NR_REQ-1:0]    gnt_o,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic                 any_o
);

  always_comb begin
    logic        found;
    int unsigned j;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NR_REQ; k++) begin
      j = (32'(ptr_i) + k) % NR_REQ;
      if (!found && valid_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_WIDTH'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/spatz_vrf_wr_arbiter.sv
// Round-robin arbiter sharing one VRF write port, with a one-entry registered output stage.
// Optional statistics counters are enabled by defining SPATZ_VRF_ARB_STATS_EN.
module spatz_vrf_wr_arbiter
  import spatz_pkg::*;
#(
  parameter int unsigned NR_REQ     = NrVrfWrReq,
  parameter int unsigned ADDR_WIDTH = $bits(vreg_addr_t),
  parameter int unsigned DATA_WIDTH = $bits(vreg_data_t),
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NR_REQ-1:0]                    req_valid_i,
  output logic [NR_REQ-1:0]                    req_ready_o,
  input  logic [NR_REQ-1:0][ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]    req_data_i,
  input  logic [NR_REQ-1:0][BE_WIDTH-1:0]      req_be_i,
  output logic [ADDR_WIDTH-1:0]                waddr_o,
  output logic [DATA_WIDTH-1:0]                wdata_o,
  output logic [BE_WIDTH-1:0]                  wbe_o,
  output logic                                 we_o,
  input  logic                                 wvalid_i,
  output logic [$clog2(NR_REQ)-1:0]            gnt_idx_o
`ifdef SPATZ_VRF_ARB_STATS_EN
  ,
  output logic [NR_REQ-1:0][31:0]              stat_gnt_o,
  output logic [31:0]                          stat_stall_o
`endif
);

  localparam int unsigned IdxW = $clog2(NR_REQ);

  logic [IdxW-1:0]       ptr_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   wbe_q;
  logic [IdxW-1:0]       gnt_idx_q;

  logic [NR_REQ-1:0] pick_gnt;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;
  logic              stage_free;
  logic              accept;

  spatz_rr_pick #(
    .NR_REQ    (NR_REQ),
    .IDX_WIDTH (IdxW)
  ) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Free when empty or when the current entry is written this cycle; reset blocks any grant.
  assign stage_free  = (~we_q | wvalid_i) & ~rst_i;
  assign accept      = stage_free & pick_any;
  assign req_ready_o = stage_free ? pick_gnt : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wbe_q     <= '0;
      gnt_idx_q <= '0;
    end else if (stage_free) begin
      we_q <= accept;
      if (accept) begin
        waddr_q   <= req_addr_i[pick_idx];
        wdata_q   <= req_data_i[pick_idx];
        wbe_q     <= req_be_i[pick_idx];
        gnt_idx_q <= pick_idx;
        ptr_q     <= (32'(pick_idx) == NR_REQ - 1) ? '0 : pick_idx + 1'b1;
      end
    end
  end

  assign we_o      = we_q;
  assign waddr_o   = waddr_q;
  assign wdata_o   = wdata_q;
  assign wbe_o     = wbe_q;
  assign gnt_idx_o = gnt_idx_q;

`ifdef SPATZ_VRF_ARB_STATS_EN
  logic [NR_REQ-1:0][31:0] stat_gnt_q;
  logic [31:0]             stat_stall_q;

  // Saturating counters: acceptances per requester and stalled write cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_gnt_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NR_REQ; i++) begin
        if (accept && pick_gnt[i] && (stat_gnt_q[i] != '1)) begin
          stat_gnt_q[i] <= stat_gnt_q[i] + 32'd1;
        end
      end
      if (we_q && !wvalid_i && (stat_stall_q != '1)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_gnt_o   = stat_gnt_q;
  assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_spatz_vrf_wr_arbiter.sv
// Directed self-checking bench for spatz_vrf_wr_arbiter (stats ports when SPATZ_VRF_ARB_STATS_EN).
module tb_spatz_vrf_wr_arbiter;
  import spatz_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = $bits(vreg_addr_t);
  localparam int unsigned DW = $bits(vreg_data_t);
  localparam int unsigned BW = DW / 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N-1:0]            req_valid;
  logic [N-1:0]            req_ready;
  logic [N-1:0][AW-1:0]    req_addr;
  logic [N-1:0][DW-1:0]    req_data;
  logic [N-1:0][BW-1:0]    req_be;
  logic [AW-1:0]           waddr;
  logic [DW-1:0]           wdata;
  logic [BW-1:0]           wbe;
  logic                    we;
  logic                    wvalid;
  logic [1:0]              gnt_idx;
`ifdef SPATZ_VRF_ARB_STATS_EN
  logic [N-1:0][31:0]      stat_gnt;
  logic [31:0]             stat_stall;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spatz_vrf_wr_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_be_i    (req_be),
    .waddr_o     (waddr),
    .wdata_o     (wdata),
    .wbe_o       (wbe),
    .we_o        (we),
    .wvalid_i    (wvalid),
    .gnt_idx_o   (gnt_idx)
`ifdef SPATZ_VRF_ARB_STATS_EN
    ,
    .stat_gnt_o   (stat_gnt),
    .stat_stall_o (stat_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_default_payload();
    vrf_wreq_t w;
    for (int i = 0; i < N; i++) begin
      w.addr = 8'(8'h10 + i);
      w.data = 32'hA000_0000 + 32'(i);
      w.be   = 4'(4'h1 << i);
      req_addr[i] = w.addr;
      req_data[i] = w.data;
      req_be[i]   = w.be;
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    wvalid    = 1'b0;
    load_default_payload();

    // Reset with all requesters valid
    step();
    chk("rst_we", we, 1'b0);
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_waddr", waddr, 8'h00);
    chk("rst_gnt_idx", gnt_idx, 2'd0);
    rst = 1'b0;
    #1;
    chk("first_ready", req_ready, 3'b001);
    step();
    chk("first_we", we, 1'b1);
    chk("first_idx", gnt_idx, 2'd0);
    chk("first_addr", waddr, 8'h10);

    // Drain: no valids, VRF accepts
    req_valid = '0;
    wvalid    = 1'b1;
    #1;
    chk("drain_ready", req_ready, 3'b000);
    step();
    chk("drain_we", we, 1'b0);
    step();
    chk("idle_wvalid_ignored", we, 1'b0);

    // Single requester 1
    req_valid   = 3'b010;
    req_addr[1] = 8'h05;
    req_data[1] = 32'hDEAD_BEEF;
    req_be[1]   = 4'hF;
    #1;
    chk("single_ready", req_ready, 3'b010);
    step();
    chk("single_we", we, 1'b1);
    chk("single_addr", waddr, 8'h05);
    chk("single_data", wdata, 32'hDEAD_BEEF);
    chk("single_be", wbe, 4'hF);
    chk("single_idx", gnt_idx, 2'd1);

    // Round-robin from a fresh pointer
    req_valid = '0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    load_default_payload();
    req_valid = '1;
    wvalid    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", req_ready, 3'b001 << (k % 3));
      step();
      chk("rr_we", we, 1'b1);
      chk("rr_idx", gnt_idx, 64'(k % 3));
      chk("rr_addr", waddr, 64'(8'h10 + (k % 3)));
      chk("rr_data", wdata, 64'(32'hA000_0000 + (k % 3)));
    end

    // Stall holds requester 2's entry
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", req_ready, 3'b000);
      step();
      chk("stall_we", we, 1'b1);
      chk("stall_idx", gnt_idx, 2'd2);
      chk("stall_addr", waddr, 8'h12);
      chk("stall_be", wbe, 4'h4);
    end
    wvalid = 1'b1;
    #1;
    chk("unstall_ready", req_ready, 3'b001);
    step();
    chk("unstall_idx", gnt_idx, 2'd0);
    chk("unstall_addr", waddr, 8'h10);

    // Reset while stalled drops the entry and rewinds the pointer
    wvalid = 1'b0;
    rst    = 1'b1;
    step();
    chk("midrst_we", we, 1'b0);
    chk("midrst_addr", waddr, 8'h00);
    rst    = 1'b0;
    wvalid = 1'b1;
    #1;
    chk("midrst_ptr_ready", req_ready, 3'b001);
    step();
    chk("midrst_idx", gnt_idx, 2'd0);

`ifdef SPATZ_VRF_ARB_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("stat_rst_gnt", stat_gnt, '0);
    chk("stat_rst_stall", stat_stall, 32'd0);
    wvalid = 1'b1;
    for (int k = 0; k < 6; k++) step();
    wvalid = 1'b0;
    step();
    step();
    chk("stat_gnt0", stat_gnt[0], 32'd2);
    chk("stat_gnt1", stat_gnt[1], 32'd2);
    chk("stat_gnt2", stat_gnt[2], 32'd2);
    chk("stat_stall", stat_stall, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
